// File: rtl/midi_msg_parser.sv
// midi_msg_parser: assembles raw MIDI bytes into whole channel/system messages.
// Handles running status, real-time interleaving and SysEx discarding.

`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE        4
`define MIDI_CMD_NOTE_OFF    4'd1
`define MIDI_CMD_NOTE_ON     4'd2
`define MIDI_CMD_AFTERTOUCH  4'd3
`define MIDI_CMD_CC          4'd4
`define MIDI_CMD_PATCH_CHG   4'd5
`define MIDI_CMD_CH_PRESSURE 4'd6
`define MIDI_CMD_PITCH_BEND  4'd7
`define MIDI_CMD_SYSTEM      4'd8
`endif

module midi_msg_parser #(
  parameter bit NOTE_ON_VEL0_IS_OFF = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_byte_rdy,
  input  logic [7:0]                rx_byte,
  output logic                      midi_rdy,
  output logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
  output logic [3:0]                midi_ch_sysn,
  output logic [6:0]                midi_data0,
  output logic [6:0]                midi_data1,
  output logic                      parse_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_D0, S_WAIT_D1, S_SYSEX} state_t;

  state_t                    r_state, w_state_nxt;
  logic [7:0]                r_status, w_status_nxt;  // status of message in progress / running status
  logic                      r_rs_vld, w_rs_vld_nxt;  // running status usable for bare data bytes
  logic [6:0]                r_d0, w_d0_nxt;          // first data byte of a 2-byte message

  logic                      r_rdy, r_err;
  logic [`MIDI_CMD_SIZE-1:0] r_cmd;
  logic [3:0]                r_ch;
  logic [6:0]                r_o_d0, r_o_d1;

  logic                      w_emit, w_err;
  logic [7:0]                w_e_stat;
  logic [6:0]                w_e_d0, w_e_d1;
  logic [`MIDI_CMD_SIZE-1:0] w_e_cmd;

  // Number of data bytes a status byte expects (only meaningful for statuses that wait).
  function automatic logic [1:0] f_need(input logic [7:0] s);
    if (s[7:4] == 4'hC || s[7:4] == 4'hD)      return 2'd1;
    else if (s == 8'hF1 || s == 8'hF3)         return 2'd1;
    else if (s == 8'hF6 || s[7:3] == 5'b11111) return 2'd0;
    else                                       return 2'd2;
  endfunction

  // Next-state, running-status tracking and message emission decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    w_rs_vld_nxt = r_rs_vld;
    w_d0_nxt     = r_d0;
    w_emit       = 1'b0;
    w_err        = 1'b0;
    w_e_stat     = r_status;
    w_e_d0       = 7'd0;
    w_e_d1       = 7'd0;
    if (rx_byte_rdy) begin
      if (rx_byte >= 8'hF8) begin
        // real-time: emitted in place, everything else untouched
        w_emit   = 1'b1;
        w_e_stat = rx_byte;
      end else if (r_state == S_SYSEX) begin
        if (rx_byte == 8'hF7) w_state_nxt = S_IDLE;
      end else if (rx_byte[7]) begin
        // any other status byte abandons a partially collected message
        w_err       = (r_state == S_WAIT_D0) || (r_state == S_WAIT_D1);
        w_state_nxt = S_IDLE;
        if (rx_byte < 8'hF0) begin
          w_status_nxt = rx_byte;
          w_rs_vld_nxt = 1'b1;
          w_state_nxt  = S_WAIT_D0;
        end else begin
          case (rx_byte[3:0])
            4'h0: begin
              w_rs_vld_nxt = 1'b0;
              w_state_nxt  = S_SYSEX;
            end
            4'h1, 4'h2, 4'h3: begin
              w_rs_vld_nxt = 1'b0;
              w_status_nxt = rx_byte;
              w_state_nxt  = S_WAIT_D0;
            end
            4'h4, 4'h5: begin
              w_rs_vld_nxt = 1'b0;
              w_err        = 1'b1;
            end
            4'h6: begin
              w_rs_vld_nxt = 1'b0;
              w_emit       = 1'b1;
              w_e_stat     = rx_byte;
            end
            default: ;  // stray F7: ignored
          endcase
        end
      end else begin
        if (r_state == S_WAIT_D1) begin
          w_emit      = 1'b1;
          w_e_d0      = r_d0;
          w_e_d1      = rx_byte[6:0];
          w_state_nxt = S_IDLE;
        end else if (r_state == S_IDLE && !r_rs_vld) begin
          w_err = 1'b1;
        end else if (f_need(r_status) == 2'd1) begin
          w_emit      = 1'b1;
          w_e_d0      = rx_byte[6:0];
          w_state_nxt = S_IDLE;
        end else begin
          w_d0_nxt    = rx_byte[6:0];
          w_state_nxt = S_WAIT_D1;
        end
      end
    end
  end

  // Command code for the message being emitted.
  always_comb begin
    case (w_e_stat[7:4])
      4'h8:    w_e_cmd = `MIDI_CMD_NOTE_OFF;
      4'h9:    w_e_cmd = (NOTE_ON_VEL0_IS_OFF && w_e_d1 == 7'd0) ? `MIDI_CMD_NOTE_OFF
                                                                : `MIDI_CMD_NOTE_ON;
      4'hA:    w_e_cmd = `MIDI_CMD_AFTERTOUCH;
      4'hB:    w_e_cmd = `MIDI_CMD_CC;
      4'hC:    w_e_cmd = `MIDI_CMD_PATCH_CHG;
      4'hD:    w_e_cmd = `MIDI_CMD_CH_PRESSURE;
      4'hE:    w_e_cmd = `MIDI_CMD_PITCH_BEND;
      default: w_e_cmd = `MIDI_CMD_SYSTEM;
    endcase
  end

  // State, parse context and registered output bus; bus fields only move with midi_rdy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_status <= 8'd0;
      r_rs_vld <= 1'b0;
      r_d0     <= 7'd0;
      r_rdy    <= 1'b0;
      r_err    <= 1'b0;
      r_cmd    <= '0;
      r_ch     <= 4'd0;
      r_o_d0   <= 7'd0;
      r_o_d1   <= 7'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      r_rs_vld <= w_rs_vld_nxt;
      r_d0     <= w_d0_nxt;
      r_rdy    <= w_emit;
      r_err    <= w_err;
      if (w_emit) begin
        r_cmd  <= w_e_cmd;
        r_ch   <= w_e_stat[3:0];
        r_o_d0 <= w_e_d0;
        r_o_d1 <= w_e_d1;
      end
    end
  end

  assign midi_rdy     = r_rdy;
  assign parse_err    = r_err;
  assign midi_cmd     = r_cmd;
  assign midi_ch_sysn = r_ch;
  assign midi_data0   = r_o_d0;
  assign midi_data1   = r_o_d1;

endmodule
